// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch port (I) and the load/store port (D).
// Define ARB_ROUND_ROBIN_EN to break simultaneous requests round-robin instead of D-first.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_done,
    output logic                    i_err,
    output logic [DATA_WIDTH-1:0]   i_rdata,

    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_done,
    output logic                    d_err,
    output logic [DATA_WIDTH-1:0]   d_rdata,

    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WD_WIDTH   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t              state;
    owner_t              owner;
    logic [WD_WIDTH-1:0] watchdog;
    logic                grant_any;
    logic                grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic                rr_last_d;   // 1 = the most recent grant went to port D
`endif

    // NOTE: always_comb assigns every output first so no latch can be inferred.
    always_comb begin
        grant_any = i_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
        grant_d   = d_req & (~i_req | ~rr_last_d);
`else
        grant_d   = d_req;
`endif
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            owner     <= OWN_NONE;
            watchdog  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_d <= 1'b1;
`endif
            i_done    <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        owner     <= grant_d ? OWN_D : OWN_I;
                        mem_req   <= 1'b1;
                        mem_we    <= grant_d & d_we;
                        mem_addr  <= grant_d ? d_addr  : i_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        mem_wstrb <= grant_d ? d_wstrb : STRB_WIDTH'(0);
                        watchdog  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_last_d <= grant_d;
`endif
                        state     <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        // Stores return zero data; loads and fetches return memory data.
                        if (owner == OWN_D) begin
                            d_done  <= 1'b1;
                            d_err   <= 1'b0;
                            d_rdata <= mem_we ? '0 : mem_rdata;
                        end else begin
                            i_done  <= 1'b1;
                            i_err   <= 1'b0;
                            i_rdata <= mem_rdata;
                        end
                        state <= ST_DONE;
                    end else if (watchdog == WD_LAST) begin
                        mem_req <= 1'b0;
                        if (owner == OWN_D) begin
                            d_done  <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            i_done  <= 1'b1;
                            i_err   <= 1'b1;
                            i_rdata <= '0;
                        end
                        state <= ST_DONE;
                    end else begin
                        watchdog <= watchdog + WD_WIDTH'(1);
                    end
                end

                ST_DONE: begin
                    // Requests are deliberately not sampled here: the finishing
                    // requester still holds req for this cycle.
                    i_done <= 1'b0;
                    i_err  <= 1'b0;
                    d_done <= 1'b0;
                    d_err  <= 1'b0;
                    owner  <= OWN_NONE;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table of single-port accesses
// plus hand-written sequences for reset mid-access and simultaneous requests.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done, i_err;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_done, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit POST_RESET_FIRST_D = 1'b0;
`else
    localparam bit POST_RESET_FIRST_D = 1'b1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory responder: wait resp_wait cycles of mem_req then assert mem_ready (-1 = never).
    int          resp_wait = 0;
    logic [31:0] resp_data = '0;
    int          grants = 0;
    int          hi_cnt = 0;
    bit          payload_bad = 1'b0;
    logic        mem_req_prev = 1'b0;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [31:0] grant_q[$];

    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            if (mem_req_prev !== 1'b1) begin
                grants++;
                hi_cnt      = 0;
                payload_bad = 1'b0;
                cap_we      = mem_we;
                cap_addr    = mem_addr;
                cap_wdata   = mem_wdata;
                cap_wstrb   = mem_wstrb;
                grant_q.push_back(mem_addr);
            end else if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !==
                         {cap_we, cap_addr, cap_wdata, cap_wstrb}) begin
                payload_bad = 1'b1;
            end
            mem_ready = (resp_wait >= 0) && (hi_cnt == resp_wait);
            mem_rdata = mem_ready ? resp_data : 32'h5A5A_5A5A;
            hi_cnt++;
        end else begin
            mem_ready = 1'b0;
        end
        mem_req_prev = mem_req;
    end

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          wait_n;
        logic [31:0] mem_data;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_cycles;   // cycles mem_req stays high
    } vec_t;

    vec_t vecs[8];

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        i_req   = 1'b0;
        d_req   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          g0;
        int          cyc;
        bit          seen;
        bit          other_bad;
        logic [31:0] other_rd;
        string       t;
        t         = $sformatf("v%0d", idx);
        g0        = grants;
        other_rd  = v.is_d ? i_rdata : d_rdata;
        resp_wait = v.wait_n;
        resp_data = v.mem_data;
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        seen = 1'b0; other_bad = 1'b0; cyc = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if ((v.is_d ? i_done : d_done) !== 1'b0) other_bad = 1'b1;
            if ((v.is_d ? d_done : i_done) === 1'b1) seen = 1'b1;
        end
        check({t, " done_seen"},      32'(seen), 1);
        check({t, " latency"},        cyc, v.exp_cycles + 1);
        check({t, " err"},            32'(v.is_d ? d_err : i_err), 32'(v.exp_err));
        check({t, " rdata"},          v.is_d ? d_rdata : i_rdata, v.exp_rdata);
        check({t, " other_done"},     32'(other_bad), 0);
        check({t, " other_rdata"},    v.is_d ? i_rdata : d_rdata, other_rd);
        check({t, " mem_req_cycles"}, hi_cnt, v.exp_cycles);
        check({t, " mem_we"},         32'(cap_we), 32'(v.is_d & v.we));
        check({t, " mem_addr"},       cap_addr, v.addr);
        check({t, " mem_wstrb"},      32'(cap_wstrb), v.is_d ? 32'(v.wstrb) : 0);
        if (v.is_d) check({t, " mem_wdata"}, cap_wdata, v.wdata);
        check({t, " payload_stable"}, 32'(payload_bad), 0);
        @(negedge clk);
        check({t, " done_one_cycle"}, 32'(i_done | d_done), 0);
        check({t, " no_regrant_in_done"}, 32'(mem_req), 0);
        if (v.is_d) d_req = 1'b0; else i_req = 1'b0;
        repeat (2) @(negedge clk);
        check({t, " grant_count"}, grants - g0, 1);
    endtask

    // Both ports request together; each drops req the cycle after its done and
    // re-raises it one cycle later, so grants alternate starting with first_d.
    task automatic both_run(input int n, input bit first_d);
        int          i_left, d_left, ip, dp, q0, cyc;
        bit          both_done;
        logic [31:0] exp_addr;
        i_left = n; d_left = n; ip = 0; dp = 0; cyc = 0; both_done = 1'b0;
        q0 = grant_q.size();
        resp_wait = 0;
        resp_data = 32'h0F0F_1234;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = '0; d_wstrb = '0;
        while ((ip != 3 || dp != 3) && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (i_done === 1'b1 && d_done === 1'b1) both_done = 1'b1;
            case (ip)
                0: if (i_done === 1'b1) begin i_left--; ip = 1; end
                1: begin i_req = 1'b0; ip = (i_left > 0) ? 2 : 3; end
                2: begin i_req = 1'b1; ip = 0; end
                default: ;
            endcase
            case (dp)
                0: if (d_done === 1'b1) begin d_left--; dp = 1; end
                1: begin d_req = 1'b0; dp = (d_left > 0) ? 2 : 3; end
                2: begin d_req = 1'b1; dp = 0; end
                default: ;
            endcase
        end
        check($sformatf("both%0d finished", n), 32'(ip == 3 && dp == 3), 1);
        check($sformatf("both%0d simultaneous_done", n), 32'(both_done), 0);
        check($sformatf("both%0d grant_count", n), grant_q.size() - q0, 2 * n);
        for (int k = 0; k < 2 * n; k++) begin
            exp_addr = (((k % 2) == 0) == first_d) ? 32'h200 : 32'h100;
            if (q0 + k < grant_q.size())
                check($sformatf("both%0d grant[%0d]", n, k), grant_q[q0 + k], exp_addr);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h10, 32'h0,        4'hF, 0,  32'h0050_0293, 32'h0050_0293, 1'b0, 1};
        vecs[1] = '{1'b0, 1'b0, 32'h14, 32'h0,        4'h0, -1, 32'h1111_1111, 32'h0,         1'b1, 16};
        vecs[2] = '{1'b1, 1'b0, 32'h24, 32'h0,        4'h0, 1,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 3,  32'h1234_5678, 32'h0,         1'b0, 4};
        vecs[4] = '{1'b1, 1'b0, 32'h28, 32'h0,        4'h3, 0,  32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 1};
        vecs[5] = '{1'b1, 1'b0, 32'h2C, 32'h0,        4'h0, -1, 32'h2222_2222, 32'h0,         1'b1, 16};
        vecs[6] = '{1'b0, 1'b1, 32'h18, 32'hFFFFFFFF, 4'hF, 2,  32'h0000_A0B1, 32'h0000_A0B1, 1'b0, 3};
        vecs[7] = '{1'b1, 1'b0, 32'h30, 32'h0,        4'h0, 1,  32'h2468_ACE0, 32'h2468_ACE0, 1'b0, 2};

        reset_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        repeat (2) @(negedge clk);
        check("reset mem_req", 32'(mem_req), 0);
        check("reset i_done",  32'(i_done | i_err), 0);
        check("reset d_done",  32'(d_done | d_err), 0);
        check("reset rdata",   i_rdata | d_rdata, 0);
        check("reset mem_bus", mem_addr | mem_wdata | 32'(mem_wstrb) | 32'(mem_we), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        // Reset in the middle of a hanging fetch.
        resp_wait = -1;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40;
        repeat (3) @(negedge clk);
        check("rst_mid mem_req_before", 32'(mem_req), 1);
        reset_n = 1'b0;
        @(negedge clk);
        i_req = 1'b0;
        check("rst_mid mem_req",   32'(mem_req), 0);
        check("rst_mid dones",     32'(i_done | i_err | d_done | d_err), 0);
        check("rst_mid i_rdata",   i_rdata, 0);
        check("rst_mid d_rdata",   d_rdata, 0);
        check("rst_mid mem_addr",  mem_addr, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid no_done_after", 32'(i_done | d_done | mem_req), 0);
        run_vec(vecs[0], 10);

        do_reset();
        both_run(4, POST_RESET_FIRST_D);
        run_vec(vecs[6], 11);
        both_run(1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
